// File: rtl/dram_bank_timing_ctrl_if.sv
// rtl/dram_bank_timing_ctrl_if.sv - command input and timing-signal bundle for dram_bank_timing_ctrl
interface dram_bank_timing_ctrl_if #(
    parameter int NUM_BANKS = 4
);
    logic                         cmd_valid;
    logic [2:0]                   cmd_type;
    logic [$clog2(NUM_BANKS)-1:0] cmd_bank;
    logic [NUM_BANKS-1:0]         tACT_done;
    logic [NUM_BANKS-1:0]         tRD_done;
    logic [NUM_BANKS-1:0]         tWR_done;
    logic [NUM_BANKS-1:0]         tPRE_done;
    logic                         tREF_done;
    logic                         rf_req;
    logic                         rd_en;
    logic                         wr_en;
    logic                         clear;
    logic [NUM_BANKS-1:0]         bank_open;
    logic                         cmd_err;

    modport master (
        output cmd_valid, cmd_type, cmd_bank,
        input  tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done,
        input  rf_req, rd_en, wr_en, clear, bank_open, cmd_err
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_bank,
        output tACT_done, tRD_done, tWR_done, tPRE_done, tREF_done,
        output rf_req, rd_en, wr_en, clear, bank_open, cmd_err
    );
endinterface

// File: rtl/dram_bank_timing_ctrl.sv
// rtl/dram_bank_timing_ctrl.sv - per-bank DRAM timing tracker with shared data-bus windows and refresh interval
module dram_bank_timing_ctrl #(
    parameter int NUM_BANKS = 4,
    parameter int tRCD      = 14,
    parameter int tCL       = 14,
    parameter int tCWL      = 12,
    parameter int tBURST    = 4,
    parameter int tWR       = 16,
    parameter int tRP       = 14,
    parameter int tRFC      = 260,
    parameter int tREFI     = 7800,
    parameter int CNT_W     = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    dram_bank_timing_ctrl_if.slave bus
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE, ACTIVATING, ACTIVE, READING, WRITING, PRECHARGING
    } bank_state_t;

    bank_state_t          state_q [NUM_BANKS];
    bank_state_t          state_d [NUM_BANKS];
    logic [CNT_W-1:0]     timer_q [NUM_BANKS];
    logic [CNT_W-1:0]     timer_d [NUM_BANKS];
    logic [NUM_BANKS-1:0] act_done_q, rd_done_q, wr_done_q, pre_done_q;
    logic [NUM_BANKS-1:0] act_done_d, rd_done_d, wr_done_d, pre_done_d;
    logic                 refreshing_q, refreshing_d;
    logic [CNT_W-1:0]     ref_timer_q, ref_timer_d;
    logic                 ref_done_q, ref_done_d;
    logic [CNT_W-1:0]     refi_cnt_q, refi_cnt_d;
    logic                 rf_req_q, rf_req_d;
    logic                 err_q, err_d;
    logic [BANK_W-1:0]    cb;
    logic                 col_busy, all_idle, rd_win, wr_win;
    logic [NUM_BANKS-1:0] open_c;

    assign cb = bus.cmd_bank;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= IDLE;
                timer_q[b] <= '0;
            end
            act_done_q   <= '0;
            rd_done_q    <= '0;
            wr_done_q    <= '0;
            pre_done_q   <= '0;
            refreshing_q <= 1'b0;
            ref_timer_q  <= '0;
            ref_done_q   <= 1'b0;
            refi_cnt_q   <= '0;
            rf_req_q     <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                state_q[b] <= state_d[b];
                timer_q[b] <= timer_d[b];
            end
            act_done_q   <= act_done_d;
            rd_done_q    <= rd_done_d;
            wr_done_q    <= wr_done_d;
            pre_done_q   <= pre_done_d;
            refreshing_q <= refreshing_d;
            ref_timer_q  <= ref_timer_d;
            ref_done_q   <= ref_done_d;
            refi_cnt_q   <= refi_cnt_d;
            rf_req_q     <= rf_req_d;
            err_q        <= err_d;
        end
    end

    // Window decode: the last read beat coincides with the done cycle, when the bank is already ACTIVE.
    always_comb begin
        col_busy = 1'b0;
        all_idle = 1'b1;
        rd_win   = 1'b0;
        wr_win   = 1'b0;
        open_c   = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (state_q[b] == READING || state_q[b] == WRITING) col_busy = 1'b1;
            if (state_q[b] != IDLE) all_idle = 1'b0;
            open_c[b] = (state_q[b] == ACTIVE) || (state_q[b] == READING) || (state_q[b] == WRITING);
            if (state_q[b] == READING && timer_q[b] < CNT_W'(tBURST)) rd_win = 1'b1;
            if (state_q[b] == WRITING && timer_q[b] >= CNT_W'(tWR)
                && timer_q[b] < CNT_W'(tWR + tBURST)) wr_win = 1'b1;
        end
    end

    always_comb begin
        act_done_d   = '0;
        rd_done_d    = '0;
        wr_done_d    = '0;
        pre_done_d   = '0;
        refreshing_d = refreshing_q;
        ref_timer_d  = ref_timer_q;
        ref_done_d   = 1'b0;
        rf_req_d     = rf_req_q;
        err_d        = 1'b0;
        refi_cnt_d   = (refi_cnt_q == CNT_W'(tREFI - 1)) ? '0 : refi_cnt_q + ONE;
        for (int b = 0; b < NUM_BANKS; b++) begin
            state_d[b] = state_q[b];
            timer_d[b] = timer_q[b];
            if (state_q[b] != IDLE && state_q[b] != ACTIVE) begin
                timer_d[b] = timer_q[b] - ONE;
                if (timer_q[b] == ONE) begin
                    case (state_q[b])
                        ACTIVATING:  begin state_d[b] = ACTIVE; act_done_d[b] = 1'b1; end
                        READING:     begin state_d[b] = ACTIVE; rd_done_d[b]  = 1'b1; end
                        WRITING:     begin state_d[b] = ACTIVE; wr_done_d[b]  = 1'b1; end
                        PRECHARGING: begin state_d[b] = IDLE;   pre_done_d[b] = 1'b1; end
                        default:     state_d[b] = state_q[b];
                    endcase
                end
            end
        end
        if (refreshing_q) begin
            ref_timer_d = ref_timer_q - ONE;
            if (ref_timer_q == ONE) begin
                refreshing_d = 1'b0;
                ref_done_d   = 1'b1;
            end
        end
        // Commands only ever act on IDLE/ACTIVE banks, so they never collide with an expiry above.
        if (bus.cmd_valid && bus.cmd_type != CMD_NOP) begin
            if (refreshing_q) begin
                err_d = 1'b1;
            end else begin
                case (bus.cmd_type)
                    CMD_ACT: if (state_q[cb] == IDLE) begin
                        state_d[cb] = ACTIVATING;
                        timer_d[cb] = CNT_W'(tRCD - 1);
                    end else err_d = 1'b1;
                    CMD_RD: if (state_q[cb] == ACTIVE && !col_busy) begin
                        state_d[cb] = READING;
                        timer_d[cb] = CNT_W'(tCL + tBURST - 1);
                    end else err_d = 1'b1;
                    CMD_WR: if (state_q[cb] == ACTIVE && !col_busy) begin
                        state_d[cb] = WRITING;
                        timer_d[cb] = CNT_W'(tCWL + tBURST + tWR - 1);
                    end else err_d = 1'b1;
                    CMD_PRE: if (state_q[cb] == ACTIVE) begin
                        state_d[cb] = PRECHARGING;
                        timer_d[cb] = CNT_W'(tRP - 1);
                    end else if (state_q[cb] == IDLE) begin
                        pre_done_d[cb] = 1'b1;
                    end else err_d = 1'b1;
                    CMD_REF: if (all_idle) begin
                        refreshing_d = 1'b1;
                        ref_timer_d  = CNT_W'(tRFC - 1);
                        rf_req_d     = 1'b0;
                    end else err_d = 1'b1;
                    default: err_d = 1'b1;
                endcase
            end
        end
        if (refi_cnt_q == CNT_W'(tREFI - 1)) rf_req_d = 1'b1;
    end

    assign bus.tACT_done = act_done_q;
    assign bus.tRD_done  = rd_done_q;
    assign bus.tWR_done  = wr_done_q;
    assign bus.tPRE_done = pre_done_q;
    assign bus.tREF_done = ref_done_q;
    assign bus.rf_req    = rf_req_q;
    assign bus.rd_en     = rd_win | (|rd_done_q);
    assign bus.wr_en     = wr_win;
    assign bus.clear     = (|act_done_q) | (|rd_done_q) | (|wr_done_q) | (|pre_done_q) | ref_done_q;
    assign bus.bank_open = open_c;
    assign bus.cmd_err   = err_q;
endmodule

// File: tb/tb_dram_bank_timing_ctrl.sv
// tb/tb_dram_bank_timing_ctrl.sv - scoreboard bench for dram_bank_timing_ctrl with an event-list reference model
module tb_dram_bank_timing_ctrl;
    localparam int NB      = 4;
    localparam int T_RCD   = 14;
    localparam int T_CL    = 14;
    localparam int T_CWL   = 12;
    localparam int T_BURST = 4;
    localparam int T_WR    = 16;
    localparam int T_RP    = 14;
    localparam int T_RFC   = 260;
    localparam int T_REFI  = 7800;

    localparam int EV_ACT = 0, EV_RD = 1, EV_WR = 2, EV_PRE = 3, EV_REF = 4, EV_ERR = 5;
    localparam int EV_RDEN = 6, EV_WREN = 7, EV_OPEN = 8, EV_CLOSE = 9, EV_RFCLR = 10, EV_NONE = 11;

    typedef struct {
        int cyc;
        int kind;
        int bank;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dram_bank_timing_ctrl_if #(.NUM_BANKS(NB)) bus ();

    dram_bank_timing_ctrl #(
        .NUM_BANKS(NB), .tRCD(T_RCD), .tCL(T_CL), .tCWL(T_CWL), .tBURST(T_BURST),
        .tWR(T_WR), .tRP(T_RP), .tRFC(T_RFC), .tREFI(T_REFI), .CNT_W(16)
    ) dut (
        .CLK (clk),
        .nRST(rst_n),
        .bus (bus)
    );

    ev_t     exp_q[$];
    int      checks = 0;
    int      failures = 0;
    int      cyc = 0;
    bit      mon_en = 1'b0;
    int      busy_until [NB];
    int      busy_kind [NB];
    bit      row_open [NB];
    int      ref_until;
    logic    exp_rf;
    logic [NB-1:0] exp_open;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", name, cyc, got, want);
        end
    endtask

    task automatic push(input int c, input int k, input int b);
        ev_t e;
        e.cyc = c; e.kind = k; e.bank = b;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NB; k++) begin
            busy_until[k] = 0;
            busy_kind[k]  = EV_NONE;
            row_open[k]   = 1'b0;
        end
        ref_until = 0;
        exp_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 3'd0;
        bus.cmd_bank  = 2'd0;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    // Reference model: a bank is busy until the cycle its done pulse fires; results are future events.
    task automatic issue(input int typ, input int b);
        int  c;
        bit  busy, anycol, allidle, ok;
        c = cyc;
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = 3'(typ);
        bus.cmd_bank  = 2'(b);
        busy = c < busy_until[b];
        anycol = 1'b0;
        allidle = 1'b1;
        for (int k = 0; k < NB; k++) begin
            if (c < busy_until[k] && (busy_kind[k] == EV_RD || busy_kind[k] == EV_WR)) anycol = 1'b1;
            if (row_open[k] || c < busy_until[k]) allidle = 1'b0;
        end
        ok = 1'b1;
        if (typ == 0) begin
            ok = 1'b1;
        end else if (c < ref_until) begin
            ok = 1'b0;
        end else begin
            case (typ)
                1: if (!busy && !row_open[b]) begin
                    row_open[b] = 1'b1; busy_until[b] = c + T_RCD; busy_kind[b] = EV_ACT;
                    push(c + T_RCD, EV_ACT, b);
                    push(c + T_RCD, EV_OPEN, b);
                end else ok = 1'b0;
                2: if (!busy && row_open[b] && !anycol) begin
                    busy_until[b] = c + T_CL + T_BURST; busy_kind[b] = EV_RD;
                    push(c + T_CL + T_BURST, EV_RD, b);
                    for (int k = 1; k <= T_BURST; k++) push(c + T_CL + k, EV_RDEN, b);
                end else ok = 1'b0;
                3: if (!busy && row_open[b] && !anycol) begin
                    busy_until[b] = c + T_CWL + T_BURST + T_WR; busy_kind[b] = EV_WR;
                    push(c + T_CWL + T_BURST + T_WR, EV_WR, b);
                    for (int k = 1; k <= T_BURST; k++) push(c + T_CWL + k, EV_WREN, b);
                end else ok = 1'b0;
                4: if (busy) ok = 1'b0;
                   else if (row_open[b]) begin
                    row_open[b] = 1'b0; busy_until[b] = c + T_RP; busy_kind[b] = EV_PRE;
                    push(c + T_RP, EV_PRE, b);
                    push(c + 1, EV_CLOSE, b);
                end else push(c + 1, EV_PRE, b);
                5: if (allidle) begin
                    ref_until = c + T_RFC;
                    push(c + T_RFC, EV_REF, 0);
                    push(c + 1, EV_RFCLR, 0);
                end else ok = 1'b0;
                default: ok = 1'b0;
            endcase
        end
        if (!ok) push(c + 1, EV_ERR, b);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic [NB-1:0] e_act, e_rd, e_wr, e_pre;
            logic e_ref, e_err, e_rden, e_wren, clr_rf;
            int i;
            e_act = '0; e_rd = '0; e_wr = '0; e_pre = '0;
            e_ref = 1'b0; e_err = 1'b0; e_rden = 1'b0; e_wren = 1'b0; clr_rf = 1'b0;
            if (cyc == 0) begin
                exp_rf   = 1'b0;
                exp_open = '0;
            end
            i = 0;
            while (i < exp_q.size()) begin
                if (exp_q[i].cyc == cyc) begin
                    case (exp_q[i].kind)
                        EV_ACT:   e_act[exp_q[i].bank] = 1'b1;
                        EV_RD:    e_rd[exp_q[i].bank]  = 1'b1;
                        EV_WR:    e_wr[exp_q[i].bank]  = 1'b1;
                        EV_PRE:   e_pre[exp_q[i].bank] = 1'b1;
                        EV_REF:   e_ref  = 1'b1;
                        EV_ERR:   e_err  = 1'b1;
                        EV_RDEN:  e_rden = 1'b1;
                        EV_WREN:  e_wren = 1'b1;
                        EV_OPEN:  exp_open[exp_q[i].bank] = 1'b1;
                        EV_CLOSE: exp_open[exp_q[i].bank] = 1'b0;
                        default:  clr_rf = 1'b1;
                    endcase
                    exp_q.delete(i);
                end else begin
                    i++;
                end
            end
            if (clr_rf) exp_rf = 1'b0;
            if (cyc > 0 && cyc % T_REFI == 0) exp_rf = 1'b1;
            chk("done_vec", 32'({bus.tACT_done, bus.tRD_done, bus.tWR_done, bus.tPRE_done, bus.tREF_done}),
                32'({e_act, e_rd, e_wr, e_pre, e_ref}));
            chk("clear", 32'(bus.clear), 32'((|e_act) | (|e_rd) | (|e_wr) | (|e_pre) | e_ref));
            chk("rd_en", 32'(bus.rd_en), 32'(e_rden));
            chk("wr_en", 32'(bus.wr_en), 32'(e_wren));
            chk("cmd_err", 32'(bus.cmd_err), 32'(e_err));
            chk("rf_req", 32'(bus.rf_req), 32'(exp_rf));
            chk("bank_open", 32'(bus.bank_open), 32'(exp_open));
        end
    end

    function automatic logic [31:0] all_outs();
        return 32'({bus.tACT_done, bus.tRD_done, bus.tWR_done, bus.tPRE_done, bus.tREF_done,
                    bus.rf_req, bus.rd_en, bus.wr_en, bus.clear, bus.cmd_err}) | 32'(bus.bank_open);
    endfunction

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_type  = 3'd0;
        bus.cmd_bank  = 2'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", all_outs(), 32'd0);
        @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cyc    = 0;
        mon_en = 1'b1;

        run_to(10);  issue(1, 2);
        run_to(20);  issue(1, 0);
        run_to(21);  issue(1, 1);
        run_to(40);  issue(2, 0);
        run_to(42);  issue(3, 1);
        run_to(45);  issue(4, 2);
        run_to(60);  issue(1, 3);
        run_to(73);  issue(4, 2);
        run_to(100); issue(3, 1);
        run_to(140); issue(4, 1);

        run_to(160);
        while (cyc < 7400) begin
            if ($urandom_range(0, 1) == 1) issue(int'($urandom_range(0, 7)), int'($urandom_range(0, NB - 1)));
            step();
        end

        for (int k = 0; k < NB; k++) begin
            run_to(7700 + k);
            issue(4, k);
        end
        run_to(7805); issue(5, 0);
        run_to(7900); issue(1, 0);

        run_to(8100); issue(1, 0);
        run_to(8120); issue(2, 0);
        run_to(8136);
        #1;
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("async_reset_outputs", all_outs(), 32'd0);
        repeat (3) @(posedge clk);
        model_reset();
        #1;
        rst_n  = 1'b1;
        cyc    = 0;
        mon_en = 1'b1;
        run_to(3);  issue(1, 1);
        run_to(30);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dram_bank_timing_ctrl.md
Name: dram_bank_timing_ctrl

Overview:
- Multi-bank successor to the single-bank timing controller behind the timing-signal bundle (tACT/tRD/tWR/tPRE/tREF done, rf_req, wr_en, rd_en, clear).
- Tracks NUM_BANKS independent bank timers, owns the shared data-bus read/write windows and the refresh interval counter.
- Sits between the command FSM (consumes done/rf_req) and the data-transfer block (consumes wr_en/rd_en/clear).

Parameters:
- NUM_BANKS, 4, number of independently timed banks (power of 2, >=2)
- tRCD, 14, ACT-to-column-ready cycles
- tCL, 14, RD-to-first-data cycles
- tCWL, 12, WR-to-first-data cycles
- tBURST, 4, data-beat cycles per column command
- tWR, 16, write-recovery cycles after last beat
- tRP, 14, PRE-to-idle cycles
- tRFC, 260, refresh busy cycles
- tREFI, 7800, refresh interval cycles
- CNT_W, 16, timer width; every timing sum must be < 2**CNT_W

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- cmd_valid  in  1  command issued this cycle
- cmd_type  in  3  0 NOP, 1 ACT, 2 RD, 3 WR, 4 PRE, 5 REF, 6-7 illegal
- cmd_bank  in  $clog2(NUM_BANKS)  target bank (ignored for REF)
- tACT_done  out  NUM_BANKS  per-bank 1-cycle pulse, row ready
- tRD_done  out  NUM_BANKS  per-bank 1-cycle pulse, read burst complete
- tWR_done  out  NUM_BANKS  per-bank 1-cycle pulse, write recovery complete
- tPRE_done  out  NUM_BANKS  per-bank 1-cycle pulse, bank idle
- tREF_done  out  1  1-cycle pulse, refresh complete
- rf_req  out  1  refresh due (level)
- rd_en  out  1  read data-beat window
- wr_en  out  1  write data-beat window
- clear  out  1  1-cycle pulse whenever any done pulse fires
- bank_open  out  NUM_BANKS  bank in ACTIVE state
- cmd_err  out  1  1-cycle pulse, command rejected

Behaviour:
- Reset: all banks IDLE, all timers 0, refresh counter 0; every output 0.
- Per-bank FSM: IDLE, ACTIVATING, ACTIVE, READING, WRITING, PRECHARGING. Global REFRESHING overrides all banks.
- Accepted command loads the bank timer with T-1 next edge; timer decrements each cycle; at 0 the FSM transitions and the matching done bit is high for that one cycle (registered).
- ACT (IDLE): timer tRCD-1, ACTIVATING; at 0 -> ACTIVE, tACT_done[b]. Pulse at cycle N+tRCD, where the command is in cycle N.
- RD (ACTIVE): timer tCL+tBURST-1, READING; rd_en high in cycles N+tCL+1 .. N+tCL+tBURST; at 0 -> ACTIVE, tRD_done[b] in the last beat cycle.
- WR (ACTIVE): timer tCWL+tBURST+tWR-1, WRITING; wr_en high in cycles N+tCWL+1 .. N+tCWL+tBURST; at 0 -> ACTIVE, tWR_done[b].
- PRE (ACTIVE): timer tRP-1, PRECHARGING; at 0 -> IDLE, tPRE_done[b]. PRE in IDLE: accepted as no-op, with tPRE_done pulse 1 cycle later.
- REF: accepted only when all banks IDLE. Global timer tRFC-1; at 0 tREF_done, banks remain IDLE. Accepted REF clears rf_req on the next edge.
- Column exclusivity: RD/WR rejected if any bank is READING or WRITING (single shared data bus).
- Rejection cases: wrong state, column conflict, illegal type, any command during REFRESHING. Result: cmd_err pulse next cycle; no state change.
- Multiple banks may finish in the same cycle; each done bit pulses independently, and clear is a single pulse.
- Refresh counter: free-running mod tREFI; rf_req set on wrap and held until REF accepted. Further wraps while pending are not accumulated. Counter does not pause during REFRESHING.
- Command and timer expiry on the same bank in the same cycle: expiry wins; the command is evaluated against the pre-transition state, so it is rejected unless legal in that state.
- Asynchronous reset mid-operation: immediate return to reset values; no done pulse emitted.

Test Plan:
- ACT bank 2 at cycle 10 -> tACT_done[2] only, at cycle 24; bank_open[2] from 24.
- ACT b0, wait done, RD at cycle 40 -> rd_en cycles 55-58, tRD_done[0] and clear at 58.
- ACT b0 and b1 (1 cycle apart), RD b0 at cycle 40, WR b1 at cycle 42 -> cmd_err at 43; rd_en window unaffected.
- WR b1 at cycle 100 -> wr_en cycles 113-116, tWR_done[1] at 132; PRE b1 at 140 -> tPRE_done[1] at 154.
- Run to cycle 7800 idle -> rf_req=1; REF at 7805 -> rf_req=0 at 7806, tREF_done at 8065; ACT at 7900 -> cmd_err.
- nRST low during READING -> rd_en, bank_open, and all done outputs 0 immediately; first legal ACT after release completes in tRCD.
